// File: rtl/mem_word_adapter.sv
// mem_word_adapter: turns byte/half/word load/store requests from the JVM core
// into a sequence of single-byte transactions on the byte-wide memory block.
// Multi-byte accesses are big-endian: the byte at the request address is the
// most significant byte of the value.
// Optional feature: define MISALIGN_TRAP_EN to reject misaligned half/word
// accesses with an error response. Without it, any alignment is accepted and
// accesses that run past the top of memory wrap to address 0.
module mem_word_adapter #(
  parameter int unsigned ADDRESS_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_rwn,
  input  logic [1:0]               req_size,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     resp_valid,
  output logic [31:0]              resp_rdata,
  output logic                     resp_err,
  output logic                     mem_start,
  output logic                     mem_rwn,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [31:0]              mem_data_in,
  input  logic [7:0]               mem_data_out,
  input  logic                     mem_ready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned BEAT_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    WAIT,
    DONE
  } state_t;

  state_t                   state_q;
  state_t                   state_d;

  logic                     rwn_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_W-1:0]        wdata_q;
  logic [BEAT_W-1:0]        beats_q;
  logic [DATA_W-1:0]        asm_q;
  logic                     err_q;

  logic [BEAT_W-1:0]        beats_c;
  logic [DATA_W-1:0]        wdata_aligned_c;
  logic                     misalign_c;
  logic                     req_err_c;
  logic                     beat_done_c;

  // Alignment check on the incoming request (only when the trap is built in)
`ifdef MISALIGN_TRAP_EN
  assign misalign_c = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  assign req_err_c   = (req_size == 2'd3) || misalign_c;
  assign beat_done_c = (state_q == WAIT) && mem_ready;

  // Beat count and store data left-justified so the next byte is always [31:24]
  always_comb begin
    beats_c         = BEAT_W'(4);
    wdata_aligned_c = req_wdata;
    case (req_size)
      2'd0: begin
        beats_c         = BEAT_W'(1);
        wdata_aligned_c = {req_wdata[7:0], 24'h000000};
      end
      2'd1: begin
        beats_c         = BEAT_W'(2);
        wdata_aligned_c = {req_wdata[15:0], 16'h0000};
      end
      default: begin
        beats_c         = BEAT_W'(4);
        wdata_aligned_c = req_wdata;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    mem_start  = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_d = req_err_c ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          mem_start = 1'b1;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        // memory drops ready only on the cycle after start, so skip one cycle
        state_d = WAIT;
      end
      WAIT: begin
        if (mem_ready) begin
          state_d = (beats_q == BEAT_W'(1)) ? DONE : ISSUE;
        end
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, address/data stepping and load-data assembly
  always_ff @(posedge clk) begin
    if (reset) begin
      rwn_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      beats_q <= '0;
      asm_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if ((state_q == IDLE) && req_valid) begin
        rwn_q   <= req_rwn;
        addr_q  <= req_addr;
        wdata_q <= wdata_aligned_c;
        beats_q <= beats_c;
        asm_q   <= '0;
        err_q   <= req_err_c;
      end else if (beat_done_c) begin
        if (rwn_q) begin
          asm_q <= {asm_q[DATA_W-BYTE_W-1:0], mem_data_out};
        end
        addr_q  <= addr_q + ADDRESS_WIDTH'(1);
        wdata_q <= {wdata_q[DATA_W-BYTE_W-1:0], BYTE_W'(0)};
        beats_q <= beats_q - BEAT_W'(1);
      end else if (state_q == DONE) begin
        err_q <= 1'b0;
      end
    end
  end

  // Memory-side and response drives come straight from the registers
  assign mem_rwn     = rwn_q;
  assign mem_address = addr_q;
  assign mem_data_in = {24'h000000, wdata_q[DATA_W-1:DATA_W-BYTE_W]};
  assign resp_rdata  = asm_q;
  assign resp_err    = err_q;

endmodule
